adder_result_checker: RTL and testbench
=======================================

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width of the checked adder.
REQ-002 Parameter N_VECTORS, default 40, vectors per run; legal range 1..2**CNT_W-1.
REQ-003 Parameter CNT_W, default 8, width of all counters.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse: clear counters, begin a run.
REQ-007 in_valid  input  1  vector present on in_a/in_b/carry_in/dut_out/dut_carry_out.
REQ-008 in_ready  output  1  checker accepts a vector this cycle.
REQ-009 in_a, in_b  input  WIDTH each  operands applied to the adder.
REQ-010 carry_in  input  1  carry applied to the adder.
REQ-011 dut_out  input  WIDTH  adder sum observed.
REQ-012 dut_carry_out  input  1  adder carry observed.
REQ-013 vec_cnt, err_cnt  output  CNT_W each  vectors checked, mismatches found.
REQ-014 done  output  1  run complete; pass  output  1  done and err_cnt==0.

Function
REQ-015 States SHALL be IDLE, RUN, DONE; reset enters IDLE.
REQ-016 start in IDLE or DONE SHALL clear vec_cnt, err_cnt, accept counter, pipeline valid and go to RUN next edge; start in RUN is ignored.
REQ-017 in_ready SHALL equal (state==RUN) and (accepted vectors < N_VECTORS), combinationally from registers only.
REQ-018 A vector is accepted on an edge where in_valid and in_ready are both 1; no other edge captures inputs.
REQ-019 Accepted vector SHALL be registered at the accept edge (stage 1); comparison result SHALL update counters at the next edge (latency 1 cycle after acceptance).
REQ-020 Expected value SHALL be {carry, sum} = in_a + in_b + carry_in computed at WIDTH+1 bits; wrap of sum beyond 2**WIDTH-1 goes to carry, e.g. 15+15+1 = {1,15}.
REQ-021 Mismatch SHALL be any difference in sum bits or carry bit; each mismatch increments err_cnt by 1.
REQ-022 vec_cnt SHALL increment by 1 for every checked vector, pass or fail.
REQ-023 When the checked vector makes vec_cnt equal N_VECTORS, state SHALL enter DONE on that same edge; done=1 from then until start or reset.
REQ-024 pass SHALL be 1 only in DONE with err_cnt==0; 0 elsewhere.
REQ-025 Back-to-back acceptance (in_valid held high) SHALL check one vector per cycle with no bubbles.
REQ-026 in_valid while in_ready=0 SHALL be ignored, no counter change.
REQ-027 start coinciding with the final check edge in RUN is ignored; DONE is entered.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, in_ready 0, vec_cnt 0, err_cnt 0, done 0, pass 0, pipeline valid 0, regardless of run in progress.
REQ-029 After rst_n release, no vector is checked until start.

Configuration
REQ-030 Macro CHECKER_FIRST_ERR_EN defined: extra outputs first_err_valid (1), first_err_a, first_err_b (WIDTH), first_err_cin (1), first_err_out (WIDTH+1, observed {carry,sum}) SHALL latch the first mismatching vector of the run, cleared by reset and start.
REQ-031 Macro undefined: those ports and registers SHALL not exist; all other behaviour identical.

Structure
REQ-032 Package adder_chk_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and default constants for WIDTH, N_VECTORS, CNT_W.
REQ-033 Sub-module ref_adder (combinational, WIDTH-parameterised, outputs {carry,sum}) SHALL compute the expected value; no other sub-modules.

Verification
REQ-034 Reset, start, vector a=3 b=4 cin=1 out=8 cout=0 -> vec_cnt 1, err_cnt 0 one cycle after accept.
REQ-035 Vector a=15 b=15 cin=1 out=15 cout=1 -> no error; same with cout=0 -> err_cnt +1 (and first_err_* = 15,15,1,{0,15} with macro).
REQ-036 N_VECTORS=40, 40 correct vectors back-to-back -> done=1, pass=1 at edge after 40th accept; in_ready 0 after 40th accept; 41st in_valid ignored.
REQ-037 40 vectors, 3 corrupted -> done=1, err_cnt=3, pass=0; start -> counters 0, RUN.
REQ-038 rst_n asserted after 20 accepted vectors -> all outputs 0 asynchronously, IDLE; vectors ignored until start.
REQ-039 in_valid toggled randomly, seeds 1..120 as operands mod 8 -> vec_cnt equals accepted handshakes exactly.

Source files
------------

// File: rtl/adder_chk_pkg.sv
// rtl/adder_chk_pkg.sv - shared state type and default sizing for the adder result checker
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_N_VECTORS = 40;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/ref_adder.sv
// rtl/ref_adder.sv - combinational reference adder producing {carry, sum}
module ref_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - checks observed adder results against a reference over a run of vectors
// Optional macro CHECKER_FIRST_ERR_EN adds capture of the first mismatching vector of each run.
module adder_result_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int N_VECTORS = DEF_N_VECTORS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] dut_out,
  input  logic             dut_carry_out,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             done,
  output logic             pass
`ifdef CHECKER_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin,
  output logic [WIDTH:0]   first_err_out
`endif
);

  localparam logic [CNT_W-1:0] LP_N_VEC = CNT_W'(N_VECTORS);
  localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);

  chk_state_e       r_state;
  chk_state_e       w_next_state;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic [WIDTH-1:0] r_s1_out;
  logic             r_s1_cout;
  logic [WIDTH:0]   w_expected;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_mismatch;
  logic             w_last_check;

  ref_adder #(.WIDTH(WIDTH)) u_ref_adder (
    .i_a   (r_s1_a),
    .i_b   (r_s1_b),
    .i_cin (r_s1_cin),
    .o_sum (w_expected)
  );

  assign in_ready     = (r_state == RUN) && (r_acc_cnt < LP_N_VEC);
  assign w_accept     = in_valid && in_ready;
  assign w_start_ok   = start && (r_state != RUN);
  assign w_mismatch   = r_s1_valid && (w_expected != {r_s1_cout, r_s1_out});
  assign w_last_check = r_s1_valid && ((r_vec_cnt + LP_ONE) == LP_N_VEC);

  assign vec_cnt = r_vec_cnt;
  assign err_cnt = r_err_cnt;
  assign done    = (r_state == DONE);
  assign pass    = (r_state == DONE) && (r_err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // The final check wins over a coinciding start: start is only honoured outside RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last_check) w_next_state = DONE;
      DONE:    if (start) w_next_state = RUN;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt  <= '0;
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_out   <= '0;
      r_s1_cout  <= 1'b0;
    end else if (w_start_ok) begin
      r_acc_cnt  <= '0;
      r_vec_cnt  <= '0;
      r_err_cnt  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + LP_ONE;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_cin  <= carry_in;
        r_s1_out  <= dut_out;
        r_s1_cout <= dut_carry_out;
      end
      if (r_s1_valid) begin
        r_vec_cnt <= r_vec_cnt + LP_ONE;
        if (w_mismatch) r_err_cnt <= r_err_cnt + LP_ONE;
      end
    end
  end

`ifdef CHECKER_FIRST_ERR_EN
  logic             r_fe_valid;
  logic [WIDTH-1:0] r_fe_a;
  logic [WIDTH-1:0] r_fe_b;
  logic             r_fe_cin;
  logic [WIDTH:0]   r_fe_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_valid <= 1'b0;
      r_fe_a     <= '0;
      r_fe_b     <= '0;
      r_fe_cin   <= 1'b0;
      r_fe_out   <= '0;
    end else if (w_start_ok) begin
      r_fe_valid <= 1'b0;
      r_fe_a     <= '0;
      r_fe_b     <= '0;
      r_fe_cin   <= 1'b0;
      r_fe_out   <= '0;
    end else if (w_mismatch && !r_fe_valid) begin
      r_fe_valid <= 1'b1;
      r_fe_a     <= r_s1_a;
      r_fe_b     <= r_s1_b;
      r_fe_cin   <= r_s1_cin;
      r_fe_out   <= {r_s1_cout, r_s1_out};
    end
  end

  assign first_err_valid = r_fe_valid;
  assign first_err_a     = r_fe_a;
  assign first_err_b     = r_fe_b;
  assign first_err_cin   = r_fe_cin;
  assign first_err_out   = r_fe_out;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// tb/tb_adder_result_checker.sv - directed self-checking bench for adder_result_checker (default build)
module tb_adder_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       carry_in;
  logic [3:0] dut_out;
  logic       dut_carry_out;
  logic [7:0] vec_cnt;
  logic [7:0] err_cnt;
  logic       done;
  logic       pass;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(4), .N_VECTORS(40), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .carry_in      (carry_in),
    .dut_out       (dut_out),
    .dut_carry_out (dut_carry_out),
    .vec_cnt       (vec_cnt),
    .err_cnt       (err_cnt),
    .done          (done),
    .pass          (pass)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] add5(input logic [3:0] a, input logic [3:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {4'b0, c};
  endfunction

  // Called at a falling edge; presents one vector for the next rising edge.
  task automatic put(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] o);
    in_valid      = 1'b1;
    in_a          = a;
    in_b          = b;
    carry_in      = c;
    dut_out       = o[3:0];
    dut_carry_out = o[4];
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] e;
    int         acc;
    logic       v;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; carry_in = 1'b0; dut_out = '0; dut_carry_out = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_vec_cnt", vec_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    rst_n = 1'b1;

    // Idle: vectors ignored until start
    put(4'd1, 4'd1, 1'b0, 5'd9);
    put(4'd1, 4'd1, 1'b0, 5'd9);
    in_valid = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_vec_cnt", vec_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);

    pulse_start();
    check("run_in_ready", in_ready, 1);
    put(4'd3, 4'd4, 1'b1, 5'd8);
    in_valid = 1'b0;
    check("lat_vec_cnt_before", vec_cnt, 0);
    @(negedge clk);
    check("v1_vec_cnt", vec_cnt, 1);
    check("v1_err_cnt", err_cnt, 0);

    put(4'd15, 4'd15, 1'b1, 5'd31);
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_ok_vec", vec_cnt, 2);
    check("wrap_ok_err", err_cnt, 0);
    put(4'd15, 4'd15, 1'b1, 5'd15);
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_bad_vec", vec_cnt, 3);
    check("wrap_bad_err", err_cnt, 1);

    pulse_start();
    check("start_in_run_vec", vec_cnt, 3);
    check("start_in_run_ready", in_ready, 1);
    check("start_in_run_done", done, 0);

    // Finish this run back-to-back; start coincides with the final check edge
    for (int i = 0; i < 37; i++) begin
      a = 4'(i % 16); b = 4'((i * 3) % 16); c = 1'(i % 2);
      put(a, b, c, add5(a, b, c));
    end
    check("last_accept_ready", in_ready, 0);
    check("pre_final_vec", vec_cnt, 39);
    check("pre_final_done", done, 0);
    start = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("final_done", done, 1);
    check("final_vec", vec_cnt, 40);
    check("final_err", err_cnt, 1);
    check("final_pass", pass, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("extra_ignored_vec", vec_cnt, 40);
    check("extra_still_done", done, 1);

    pulse_start();
    check("restart_vec", vec_cnt, 0);
    check("restart_err", err_cnt, 0);
    check("restart_done", done, 0);
    check("restart_ready", in_ready, 1);

    // 40 correct vectors back-to-back
    for (int i = 0; i < 40; i++) begin
      a = 4'(i % 16); b = 4'((i * 7) % 16); c = 1'(i % 2);
      put(a, b, c, add5(a, b, c));
    end
    in_valid = 1'b1;
    check("full_ready_low", in_ready, 0);
    check("full_pre_done", done, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("full_done", done, 1);
    check("full_pass", pass, 1);
    check("full_vec", vec_cnt, 40);
    check("full_err", err_cnt, 0);

    // 40 vectors with three corrupted
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      a = 4'((i * 5) % 16); b = 4'((i + 9) % 16); c = 1'((i / 2) % 2);
      e = add5(a, b, c);
      if (i == 5 || i == 17 || i == 39) e = e ^ 5'b10000;
      put(a, b, c, e);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("corrupt_done", done, 1);
    check("corrupt_err", err_cnt, 3);
    check("corrupt_pass", pass, 0);
    check("corrupt_vec", vec_cnt, 40);
    pulse_start();
    check("corrupt_restart_vec", vec_cnt, 0);
    check("corrupt_restart_err", err_cnt, 0);
    check("corrupt_restart_ready", in_ready, 1);
    check("corrupt_restart_done", done, 0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 20; i++) begin
      a = 4'(i % 16); b = 4'(15 - (i % 16)); c = 1'b1;
      e = add5(a, b, c);
      if (i == 2) e = e ^ 5'b00001;
      put(a, b, c, e);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_vec", vec_cnt, 20);
    check("pre_reset_err", err_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vec", vec_cnt, 0);
    check("async_rst_err", err_cnt, 0);
    check("async_rst_ready", in_ready, 0);
    check("async_rst_done", done, 0);
    check("async_rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    put(4'd2, 4'd2, 1'b0, 5'd4);
    put(4'd2, 4'd2, 1'b0, 5'd4);
    put(4'd2, 4'd2, 1'b0, 5'd4);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_vec", vec_cnt, 0);
    check("post_rst_ready", in_ready, 0);

    // Random in_valid; count handshakes with an independent model
    pulse_start();
    acc = 0;
    for (int k = 1; k <= 120; k++) begin
      v = 1'($urandom_range(0, 1));
      a = 4'(k % 8); b = 4'((k + 3) % 8); c = 1'(k % 2);
      e = add5(a, b, c);
      in_a = a; in_b = b; carry_in = c; dut_out = e[3:0]; dut_carry_out = e[4];
      in_valid = v;
      @(negedge clk);
      if (v && acc < 40) acc++;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rand_vec_cnt", vec_cnt, acc);
    check("rand_err_cnt", err_cnt, 0);
    check("rand_done", done, (acc == 40) ? 1 : 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
